// File: rtl/pwm_capture_if.sv
// Signal bundle between pwm_capture and its consumer: the raw PWM input plus
// the measurement results and status flags.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic             pwm_in;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             meas_valid;
  logic             stuck_high;
  logic             stuck_low;
  logic [6:0]       duty_pct;
  logic             pct_valid;

  modport master (
    input  pwm_in,
    output high_cnt, period_cnt, meas_valid, stuck_high, stuck_low,
    output duty_pct, pct_valid
  );

  modport slave (
    output pwm_in,
    input  high_cnt, period_cnt, meas_valid, stuck_high, stuck_low,
    input  duty_pct, pct_valid
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM receiver: measures high time and period of pwm_in in clk_50M cycles and
// flags stuck inputs. Define PWM_CAP_DUTY_PCT_EN to add the duty-cycle divider.
module pwm_capture #(
  parameter int CNT_W = 16
) (
  input  logic           clk_50M,
  input  logic           reset,
  pwm_capture_if.master  cap
);
  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  typedef enum logic [1:0] {IDLE, ARMED, HIGH, LOW} state_t;

  state_t           state, state_nxt;
  logic             s1, s2, d;
  logic [1:0]       sync_fill;
  logic [CNT_W-1:0] cnt, cnt_nxt, high_lat;
  logic             rise, fall, timeout;
  logic             latch_high, publish, set_sh, set_sl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX_CNT) ? v : v + CNT_W'(1);
  endfunction

  assign rise    = s2 & ~d;
  assign fall    = ~s2 & d;
  assign timeout = (cnt == MAX_CNT);

  // Stage: input synchroniser and edge-detect delay.
  // sync_fill keeps IDLE from trusting s2 until the synchroniser holds real input,
  // so an input already high at reset release cannot look like a rise.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      d         <= 1'b0;
      sync_fill <= '0;
    end else begin
      s1        <= cap.pwm_in;
      s2        <= s1;
      d         <= s2;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  always_ff @(posedge clk_50M) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = sat_inc(cnt);
    latch_high = 1'b0;
    publish    = 1'b0;
    set_sh     = 1'b0;
    set_sl     = 1'b0;
    case (state)
      IDLE: begin
        if (sync_fill[1] && !s2) state_nxt = ARMED;
        if (timeout) begin
          cnt_nxt = '0;
          set_sh  = s2;
          set_sl  = ~s2;
        end
      end
      ARMED: begin
        if (rise) begin
          state_nxt = HIGH;
          cnt_nxt   = CNT_W'(1);
        end else if (timeout) begin
          cnt_nxt = '0;
          set_sh  = s2;
          set_sl  = ~s2;
        end
      end
      HIGH: begin
        if (fall) begin
          latch_high = 1'b1;
          state_nxt  = LOW;
        end else if (timeout) begin
          set_sh    = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      LOW: begin
        if (rise) begin
          publish   = 1'b1;
          state_nxt = HIGH;
          cnt_nxt   = CNT_W'(1);
        end else if (timeout) begin
          set_sl    = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (latch_high) high_lat <= cnt;
  end

  // Stage: counter and published results.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      cnt            <= '0;
      cap.high_cnt   <= '0;
      cap.period_cnt <= '0;
      cap.meas_valid <= 1'b0;
      cap.stuck_high <= 1'b0;
      cap.stuck_low  <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      cap.meas_valid <= publish;
      if (publish) begin
        cap.period_cnt <= cnt;
        cap.high_cnt   <= high_lat;
        cap.stuck_high <= 1'b0;
        cap.stuck_low  <= 1'b0;
      end else begin
        if (set_sh) cap.stuck_high <= 1'b1;
        if (set_sl) cap.stuck_low  <= 1'b1;
      end
    end
  end

`ifdef PWM_CAP_DUTY_PCT_EN
  localparam int NUM_W = CNT_W + 7;

  logic             busy;
  logic [2:0]       iter;
  logic [NUM_W-1:0] rem, den_sh, num_ld, den_ld;
  logic [6:0]       quo;
  logic             q_bit;

  assign num_ld = NUM_W'(cap.high_cnt) * NUM_W'(100);
  assign den_ld = NUM_W'(cap.period_cnt) << 6;
  assign q_bit  = (rem >= den_sh);

  // Stage: restoring divider control; a fresh meas_valid restarts it.
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      busy          <= 1'b0;
      iter          <= '0;
      cap.pct_valid <= 1'b0;
      cap.duty_pct  <= '0;
    end else begin
      cap.pct_valid <= 1'b0;
      if (cap.meas_valid) begin
        busy <= 1'b1;
        iter <= '0;
      end else if (busy) begin
        iter <= iter + 3'd1;
        if (iter == 3'd6) begin
          busy          <= 1'b0;
          cap.pct_valid <= 1'b1;
          cap.duty_pct  <= {quo[5:0], q_bit};
        end
      end
    end
  end

  // Quotient never exceeds 100 because high time cannot exceed the period.
  always_ff @(posedge clk_50M) begin
    if (cap.meas_valid) begin
      rem    <= num_ld;
      den_sh <= den_ld;
      quo    <= '0;
    end else if (busy) begin
      if (q_bit) rem <= rem - den_sh;
      den_sh <= den_sh >> 1;
      quo    <= {quo[5:0], q_bit};
    end
  end
`else
  assign cap.duty_pct  = '0;
  assign cap.pct_valid = 1'b0;
`endif

endmodule
